// File: rtl/fir_ctrl_regs.sv
// Purpose: FIR control/status register bank with run-control FSM (start, soft reset, done/err tracking).
// Latency: register writes visible on outputs 1 cycle after the write strobe; rd_data is combinational.
// Backpressure: none; every write strobe is accepted, START while not idle is dropped and flags ERR.
module fir_ctrl_regs #(
   parameter int          DATA_W        = 16,
   parameter logic [15:0] VERSION       = 16'h0101,
   parameter int          START_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_Rej,
   input  logic [2:0]        nr_Rejestru,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              fir_start,
   output logic              fir_soft_rst,
   input  logic              fir_busy,
   input  logic              fir_done,
   input  logic              fir_sample_valid,
   output logic [4:0]        n_taps,
   output logic [15:0]       n_samples,
   output logic [4:0]        out_shift,
   output logic              irq
);

   // Register indices
   localparam logic [2:0] REG_CTRL       = 3'd0;
   localparam logic [2:0] REG_STATUS     = 3'd1;
   localparam logic [2:0] REG_NTAPS      = 3'd2;
   localparam logic [2:0] REG_NSAMPLES   = 3'd3;
   localparam logic [2:0] REG_SHIFT      = 3'd4;
   localparam logic [2:0] REG_SCRATCH    = 3'd5;
   localparam logic [2:0] REG_VERSION    = 3'd6;
   localparam logic [2:0] REG_SAMPLE_CNT = 3'd7;

   // Run-control FSM states
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;

   localparam logic [7:0] TMO_LOAD = 8'(START_TIMEOUT);

   // Register state
   logic              irq_en_q,       irq_en_d;
   logic              done_q,         done_d;
   logic              err_q,          err_d;
   logic [4:0]        ntaps_q,        ntaps_d;
   logic [15:0]       nsamples_q,     nsamples_d;
   logic [4:0]        shift_q,        shift_d;
   logic [DATA_W-1:0] scratch_q,      scratch_d;
   logic [15:0]       sample_cnt_q,   sample_cnt_d;
   logic [1:0]        state_q,        state_d;
   logic [7:0]        tmo_q,          tmo_d;
   logic              fir_start_q,    fir_start_d;
   logic              fir_soft_rst_q, fir_soft_rst_d;
   logic              irq_q,          irq_d;

   // Decoded write strobes
   logic wr_ctrl;
   logic wr_status;
   logic start_req;
   logic soft_req;
   logic done_set;
   logic err_set;
   logic cnt_clr;

   // Decode the register write strobes; SOFT_RST masks START in the same write
   always_comb begin
      wr_ctrl   = wr_Rej && (nr_Rejestru == REG_CTRL);
      wr_status = wr_Rej && (nr_Rejestru == REG_STATUS);
      soft_req  = wr_ctrl && wr_data[1];
      start_req = wr_ctrl && wr_data[0] && !wr_data[1];
   end

   // Run-control FSM: start handshake, busy timeout, completion and soft reset
   always_comb begin
      state_d        = state_q;
      tmo_d          = tmo_q;
      fir_start_d    = 1'b0;
      fir_soft_rst_d = soft_req;
      done_set       = 1'b0;
      err_set        = 1'b0;
      cnt_clr        = 1'b0;
      if (soft_req) begin
         state_d = ST_IDLE;
         tmo_d   = 8'd0;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_req) begin
                  fir_start_d = 1'b1;
                  cnt_clr     = 1'b1;
                  tmo_d       = TMO_LOAD;
                  state_d     = ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (start_req) begin
                  err_set = 1'b1;
               end
               if (fir_done) begin
                  done_set = 1'b1;
                  tmo_d    = 8'd0;
                  state_d  = ST_IDLE;
               end else if (fir_busy) begin
                  tmo_d   = 8'd0;
                  state_d = ST_RUN;
               end else if (tmo_q <= 8'd1) begin
                  // Counter reaches zero on this edge: the core never went busy
                  err_set = 1'b1;
                  tmo_d   = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q - 8'd1;
               end
            end
            ST_RUN: begin
               if (start_req) begin
                  err_set = 1'b1;
               end
               if (fir_done) begin
                  done_set = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               tmo_d   = 8'd0;
            end
         endcase
      end
   end

   // Configuration registers and sticky status flags (hardware set beats W1C)
   always_comb begin
      irq_en_d   = irq_en_q;
      ntaps_d    = ntaps_q;
      nsamples_d = nsamples_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      if (wr_ctrl) begin
         irq_en_d = wr_data[2];
      end
      if (wr_Rej && (nr_Rejestru == REG_NTAPS)) begin
         ntaps_d = wr_data[4:0];
      end
      if (wr_Rej && (nr_Rejestru == REG_NSAMPLES)) begin
         nsamples_d = wr_data[15:0];
      end
      if (wr_Rej && (nr_Rejestru == REG_SHIFT)) begin
         shift_d = wr_data[4:0];
      end
      if (wr_Rej && (nr_Rejestru == REG_SCRATCH)) begin
         scratch_d = wr_data;
      end
      done_d = (done_q && !(wr_status && wr_data[1])) || done_set;
      err_d  = (err_q  && !(wr_status && wr_data[2])) || err_set;
      irq_d  = irq_en_q && (done_q || err_q);
   end

   // Output sample counter: counts only while running, saturates, cleared on start/soft reset
   always_comb begin
      sample_cnt_d = sample_cnt_q;
      if (cnt_clr) begin
         sample_cnt_d = 16'd0;
      end else if ((state_q == ST_RUN) && fir_sample_valid && (sample_cnt_q != 16'hFFFF)) begin
         sample_cnt_d = sample_cnt_q + 16'd1;
      end
   end

   // State flops with asynchronous reset to all-zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en_q       <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         ntaps_q        <= 5'd0;
         nsamples_q     <= 16'd0;
         shift_q        <= 5'd0;
         scratch_q      <= '0;
         sample_cnt_q   <= 16'd0;
         state_q        <= ST_IDLE;
         tmo_q          <= 8'd0;
         fir_start_q    <= 1'b0;
         fir_soft_rst_q <= 1'b0;
         irq_q          <= 1'b0;
      end else begin
         irq_en_q       <= irq_en_d;
         done_q         <= done_d;
         err_q          <= err_d;
         ntaps_q        <= ntaps_d;
         nsamples_q     <= nsamples_d;
         shift_q        <= shift_d;
         scratch_q      <= scratch_d;
         sample_cnt_q   <= sample_cnt_d;
         state_q        <= state_d;
         tmo_q          <= tmo_d;
         fir_start_q    <= fir_start_d;
         fir_soft_rst_q <= fir_soft_rst_d;
         irq_q          <= irq_d;
      end
   end

   // Combinational read-back mux; unused bits read zero
   always_comb begin
      rd_data = '0;
      case (nr_Rejestru)
         REG_CTRL:       rd_data[2]    = irq_en_q;
         REG_STATUS:     rd_data[2:0]  = {err_q, done_q, (state_q != ST_IDLE)};
         REG_NTAPS:      rd_data[4:0]  = ntaps_q;
         REG_NSAMPLES:   rd_data[15:0] = nsamples_q;
         REG_SHIFT:      rd_data[4:0]  = shift_q;
         REG_SCRATCH:    rd_data       = scratch_q;
         REG_VERSION:    rd_data[15:0] = VERSION;
         REG_SAMPLE_CNT: rd_data[15:0] = sample_cnt_q;
         default:        rd_data       = '0;
      endcase
   end

   assign fir_start    = fir_start_q;
   assign fir_soft_rst = fir_soft_rst_q;
   assign n_taps       = ntaps_q;
   assign n_samples    = nsamples_q;
   assign out_shift    = shift_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_fir_ctrl_regs.sv
// Purpose: directed self-checking bench for fir_ctrl_regs register map and run-control FSM.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: not applicable; all stimulus is directed with hand-computed expectations.
module tb_fir_ctrl_regs;

   logic        clk;
   logic        rst;
   logic        wr_Rej;
   logic [2:0]  nr_Rejestru;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic        fir_start;
   logic        fir_soft_rst;
   logic        fir_busy;
   logic        fir_done;
   logic        fir_sample_valid;
   logic [4:0]  n_taps;
   logic [15:0] n_samples;
   logic [4:0]  out_shift;
   logic        irq;

   int checks;
   int errors;
   int n_start;
   int n_soft;

   fir_ctrl_regs #(
      .DATA_W        (16),
      .VERSION       (16'h0101),
      .START_TIMEOUT (15)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .wr_Rej           (wr_Rej),
      .nr_Rejestru      (nr_Rejestru),
      .wr_data          (wr_data),
      .rd_data          (rd_data),
      .fir_start        (fir_start),
      .fir_soft_rst     (fir_soft_rst),
      .fir_busy         (fir_busy),
      .fir_done         (fir_done),
      .fir_sample_valid (fir_sample_valid),
      .n_taps           (n_taps),
      .n_samples        (n_samples),
      .out_shift        (out_shift),
      .irq              (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Count pulses seen on the core-facing strobes
   always @(negedge clk) begin
      if (fir_start)    n_start++;
      if (fir_soft_rst) n_soft++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] idx, input logic [15:0] dat);
      wr_Rej      = 1'b1;
      nr_Rejestru = idx;
      wr_data     = dat;
      tick();
      wr_Rej  = 1'b0;
      wr_data = 16'd0;
   endtask

   task automatic read_chk(input string tag, input logic [2:0] idx, input logic [15:0] exp);
      nr_Rejestru = idx;
      #1;
      chk(tag, rd_data, exp);
   endtask

   logic [15:0] reset_vals [8];

   initial begin
      checks = 0; errors = 0; n_start = 0; n_soft = 0;
      rst = 1'b1; wr_Rej = 1'b0; nr_Rejestru = 3'd0; wr_data = 16'd0;
      fir_busy = 1'b0; fir_done = 1'b0; fir_sample_valid = 1'b0;
      reset_vals = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0101, 16'h0};
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      for (int i = 0; i < 8; i++) read_chk($sformatf("rst_reg%0d", i), 3'(i), reset_vals[i]);
      chk("rst_outs", {fir_start, fir_soft_rst, irq, n_taps, n_samples, out_shift}, 32'd0);

      // Config registers: 1-cycle latency, masked widths
      wr_Rej = 1'b1; nr_Rejestru = 3'd2; wr_data = 16'hFFFF;
      #1;
      chk("ntaps_before_edge", n_taps, 5'd0);
      tick();
      wr_Rej = 1'b0;
      chk("ntaps_out", n_taps, 5'd31);
      read_chk("ntaps_rd", 3'd2, 16'd31);
      write_reg(3'd3, 16'd1000);
      chk("nsamples_out", n_samples, 16'd1000);
      read_chk("nsamples_rd", 3'd3, 16'd1000);
      write_reg(3'd4, 16'h00EF);
      chk("shift_out", out_shift, 5'd15);
      read_chk("shift_rd", 3'd4, 16'd15);
      write_reg(3'd5, 16'hA5C3);
      read_chk("scratch_rd", 3'd5, 16'hA5C3);
      write_reg(3'd6, 16'hFFFF);
      read_chk("version_ro", 3'd6, 16'h0101);

      // Normal run: START + IRQ_EN
      write_reg(3'd0, 16'h0005);
      chk("start_pulse", fir_start, 1'b1);
      read_chk("ctrl_rd", 3'd0, 16'h0004);
      read_chk("status_busy", 3'd1, 16'h0001);
      tick();
      chk("start_one_cycle", fir_start, 1'b0);
      tick();
      fir_busy = 1'b1;
      tick();
      for (int p = 0; p < 4; p++) begin
         fir_sample_valid = 1'b1;
         tick();
         fir_sample_valid = 1'b0;
         tick();
      end
      read_chk("sample_cnt", 3'd7, 16'd4);
      fir_done = 1'b1;
      tick();
      fir_done = 1'b0;
      fir_busy = 1'b0;
      read_chk("status_done", 3'd1, 16'h0002);
      chk("irq_not_yet", irq, 1'b0);
      tick();
      chk("irq_after_done", irq, 1'b1);
      chk("start_count_run", n_start, 1);
      write_reg(3'd1, 16'h0002);
      read_chk("status_w1c", 3'd1, 16'h0000);
      tick();
      chk("irq_cleared", irq, 1'b0);
      read_chk("sample_cnt_kept", 3'd7, 16'd4);

      // Busy timeout
      write_reg(3'd0, 16'h0005);
      read_chk("cnt_cleared", 3'd7, 16'd0);
      repeat (14) tick();
      read_chk("tmo_still_wait", 3'd1, 16'h0001);
      tick();
      read_chk("tmo_err", 3'd1, 16'h0004);
      tick();
      chk("irq_on_err", irq, 1'b1);
      chk("start_count_tmo", n_start, 2);
      write_reg(3'd1, 16'h0004);
      read_chk("err_w1c", 3'd1, 16'h0000);

      // START during RUN, then SOFT_RST with START
      write_reg(3'd0, 16'h0005);
      fir_busy = 1'b1;
      tick();
      read_chk("run_busy", 3'd1, 16'h0001);
      write_reg(3'd0, 16'h0005);
      chk("no_restart", fir_start, 1'b0);
      read_chk("restart_err", 3'd1, 16'h0005);
      chk("start_count_dup", n_start, 3);
      write_reg(3'd0, 16'h0003);
      chk("soft_pulse", fir_soft_rst, 1'b1);
      chk("soft_no_start", fir_start, 1'b0);
      read_chk("soft_idle", 3'd1, 16'h0004);
      tick();
      chk("soft_one_cycle", fir_soft_rst, 1'b0);
      chk("soft_count", n_soft, 1);
      chk("start_count_soft", n_start, 3);
      fir_busy = 1'b0;
      write_reg(3'd1, 16'h0004);

      // Asynchronous reset mid-RUN
      write_reg(3'd0, 16'h0005);
      fir_busy = 1'b1;
      tick();
      fir_sample_valid = 1'b1;
      tick();
      fir_sample_valid = 1'b0;
      read_chk("pre_rst_cnt", 3'd7, 16'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_outs", {fir_start, fir_soft_rst, irq, n_taps, n_samples, out_shift}, 32'd0);
      read_chk("arst_status", 3'd1, 16'h0000);
      read_chk("arst_cnt", 3'd7, 16'h0000);
      read_chk("arst_ctrl", 3'd0, 16'h0000);
      fir_busy = 1'b0;
      #2;
      rst = 1'b0;
      tick();
      write_reg(3'd0, 16'h0001);
      chk("restart_pulse", fir_start, 1'b1);
      read_chk("restart_busy", 3'd1, 16'h0001);
      fir_busy = 1'b1;
      tick();
      fir_done = 1'b1;
      tick();
      fir_done = 1'b0;
      fir_busy = 1'b0;
      read_chk("restart_done", 3'd1, 16'h0002);
      tick();
      chk("irq_disabled", irq, 1'b0);
      chk("start_count_final", n_start, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_ctrl_regs.md
Name: fir_ctrl_regs

Overview:
Control/status register bank for the FIR filter, placed directly downstream of the address decoder. It consumes the decoder's register-select and write strobe together with the write data, and holds the filter configuration. A small run-control FSM issues start requests to the FIR core and tracks completion. It also provides register read-back data to the decoder-driven output mux.

Parameters:
DATA_W, 16, width of write data and read-back bus (min 16)
VERSION, 16'h0101, constant returned by register 6
START_TIMEOUT, 15, cycles to wait for fir_busy after a start pulse before flagging error (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_Rej  in  1  register write strobe from decoder, one cycle per write
nr_Rejestru  in  3  register index from decoder
wr_data  in  DATA_W  write data
rd_data  out  DATA_W  combinational read-back of register nr_Rejestru
fir_start  out  1  one-cycle start pulse to FIR core
fir_soft_rst  out  1  one-cycle core soft reset pulse
fir_busy  in  1  core busy level
fir_done  in  1  core completion pulse
fir_sample_valid  in  1  core output-sample pulse
n_taps  out  5  tap count minus 1 (0..31 → 1..32 taps)
n_samples  out  16  samples to process
out_shift  out  5  output scaling shift
irq  out  1  interrupt level

Behaviour:
- Register map; unlisted bits read 0 and ignore writes:
  - 0 CTRL: bit0 START (W, self-clearing, reads 0); bit1 SOFT_RST (W, self-clearing, reads 0); bit2 IRQ_EN (RW).
  - 1 STATUS: bit0 BUSY (RO = FSM not IDLE); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C).
  - 2 NTAPS [4:0] RW. 3 NSAMPLES [15:0] RW. 4 SHIFT [4:0] RW. 5 SCRATCH [DATA_W-1:0] RW.
  - 6 VERSION RO. 7 SAMPLE_CNT [15:0] RO; cleared when a start is accepted.
- Reset: all registers 0; fir_start=0, fir_soft_rst=0, irq=0; FSM=IDLE; sample count 0; NTAPS=0.
- Writes take effect on the clk edge where wr_Rej=1. n_taps, n_samples and out_shift are driven directly from the register flops (1-cycle latency from the write).
- FSM states:
  - IDLE: a write of START=1 asserts fir_start for exactly the next cycle, clears SAMPLE_CNT, and moves to WAIT_BUSY with the timeout counter loaded to START_TIMEOUT.
  - WAIT_BUSY: fir_busy=1 → RUN. Counter reaching 0 → set ERR, return to IDLE.
  - RUN: fir_done=1 → set DONE, go to IDLE. fir_done in WAIT_BUSY is also accepted: set DONE, go to IDLE.
- START written while FSM≠IDLE: ignored (no fir_start pulse); ERR is set.
- SOFT_RST=1: fir_soft_rst pulses for one cycle, FSM forced to IDLE, SAMPLE_CNT cleared; DONE and ERR are kept. SOFT_RST takes priority over START in the same write.
- SAMPLE_CNT increments on fir_sample_valid only in RUN; saturates at 16'hFFFF.
- W1C versus a hardware set in the same cycle: the hardware set wins.
- irq = IRQ_EN & (DONE | ERR), registered (one cycle after the flag).
- Config writes during RUN are accepted immediately; the core is responsible for latching its config at start.
- Async rst mid-RUN: everything returns to reset values immediately; no pulse is generated.

Test Plan:
- Reset, then read regs 0..7 → 0,0,0,0,0,0,16'h0101,0; all outputs 0.
- Write NTAPS=5'd31, NSAMPLES=16'd1000, SHIFT=5'd15 → n_taps=31, n_samples=1000, out_shift=15 the cycle after each write; read-back matches.
- Write CTRL=3'b101; drive fir_busy 3 cycles later, 4 fir_sample_valid pulses, then fir_done → exactly one fir_start pulse; STATUS goes 1 → 3'b010; SAMPLE_CNT=4; irq=1 one cycle after DONE. Write STATUS=3'b010 → DONE cleared, irq=0.
- Write START with fir_busy held 0 (START_TIMEOUT=15) → ERR set after 15 cycles in WAIT_BUSY; FSM returns to IDLE.
- Write START during RUN → no second fir_start pulse, ERR=1. Then write CTRL=3'b011 → fir_soft_rst pulses once, fir_start=0, BUSY=0.
- Assert rst asynchronously mid-RUN between clock edges → outputs and registers go to 0 immediately; the next START works normally.
